// File: rtl/iz_ctrl_pkg.sv
// Shared types and constants for the IZ_RG_22 mode scheduler.
// Holds the FSM state encoding, neuron-type selects and helpers.
package iz_ctrl_pkg;

    localparam int SEL_W  = 3;
    localparam int I_W    = 5;
    localparam int MASK_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        HOLD   = 3'd2,
        RUN    = 3'd3,
        REPORT = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [SEL_W-1:0] SEL_RS  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_IB  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_CH  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_FS  = 3'd3;
    localparam logic [SEL_W-1:0] SEL_TC  = 3'd4;
    localparam logic [SEL_W-1:0] SEL_RZ  = 3'd5;
    localparam logic [SEL_W-1:0] SEL_LTS = 3'd6;
    localparam logic [SEL_W-1:0] SEL_MIX = 3'd7;

    function automatic int max_int(input int a, input int b);
        max_int = (a > b) ? a : b;
    endfunction

    // Scanning high-to-low leaves the lowest set bit as the result.
    function automatic logic [SEL_W-1:0] lowest_set(
        input logic [MASK_W-1:0] m
    );
        lowest_set = '0;
        for (int k = MASK_W - 1; k >= 0; k--) begin
            if (m[k]) lowest_set = SEL_W'(k);
        end
    endfunction

endpackage

// File: rtl/iz_spike_counter.sv
// Rising-edge spike detector feeding a saturating counter.
// Cleared before each run; counts only while enabled.
module iz_spike_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             spike,
    output logic [CNT_W-1:0] count
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev  <= 1'b0;
            count <= '0;
        end else if (en) begin
            prev <= spike;
            if (spike && !prev && (count != {CNT_W{1'b1}})) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iz_mode_scheduler.sv
// Sequencer walking enabled neuron types through reset and run phases,
// reporting one spike count per type over a valid/ready handshake.
module iz_mode_scheduler
    import iz_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 2500,
    parameter int RUN_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [MASK_W-1:0] mode_mask,
    input  logic [I_W-1:0]    i_level,
    input  logic              nrn_spike,
    output logic              nrn_rst,
    output logic [SEL_W-1:0]  nrn_select,
    output logic [I_W-1:0]    nrn_I,
    output logic              busy,
    output logic              done,
    output logic              rpt_valid,
    output logic [SEL_W-1:0]  rpt_mode,
    output logic [CNT_W-1:0]  rpt_count,
    input  logic              rpt_ready
);

    localparam int TMAX = max_int(RST_CYCLES, RUN_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] RUN_LOAD = TW'(RUN_CYCLES - 1);

    state_t              state;
    logic [TW-1:0]       timer;
    logic [MASK_W-1:0]   pend;
    logic [SEL_W-1:0]    sel;
    logic [I_W-1:0]      cur_i;
    logic [CNT_W-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            pend  <= '0;
            sel   <= '0;
            cur_i <= '0;
        end else if (abort && (state != IDLE)) begin
            state <= IDLE;
            pend  <= '0;
            sel   <= '0;
            cur_i <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pend  <= mode_mask;
                        cur_i <= i_level;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (|pend) begin
                        sel   <= lowest_set(pend);
                        pend  <= pend & (pend - 8'd1);
                        timer <= RST_LOAD;
                        state <= HOLD;
                    end else begin
                        state <= FINISH;
                    end
                end
                HOLD: begin
                    if (timer == '0) begin
                        timer <= RUN_LOAD;
                        state <= RUN;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RUN: begin
                    if (timer == '0) begin
                        state <= REPORT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                REPORT: begin
                    if (rpt_ready) state <= SCAN;
                end
                FINISH: begin
                    sel   <= '0;
                    cur_i <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    iz_spike_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == HOLD),
        .en    (state == RUN),
        .spike (nrn_spike),
        .count (cnt)
    );

    // Counter keeps its value after a run; gate it so idle reads as zero.
    assign nrn_rst    = (state != RUN);
    assign nrn_select = sel;
    assign nrn_I      = cur_i;
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign rpt_valid  = (state == REPORT);
    assign rpt_mode   = rpt_valid ? sel : '0;
    assign rpt_count  = rpt_valid ? cnt : '0;

endmodule

// File: tb/tb_iz_mode_scheduler.sv
// Directed bench for iz_mode_scheduler with short phase lengths.
// Also exercises the spike counter alone for saturation.
module tb_iz_mode_scheduler;

    localparam int RSTC = 4;
    localparam int RUNC = 20;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    mode_mask = '0;
    logic [4:0]    i_level = '0;
    logic          nrn_spike = 1'b0;
    logic          nrn_rst;
    logic [2:0]    nrn_select;
    logic [4:0]    nrn_I;
    logic          busy;
    logic          done;
    logic          rpt_valid;
    logic [2:0]    rpt_mode;
    logic [CW-1:0] rpt_count;
    logic          rpt_ready = 1'b0;

    logic          c_clr = 1'b0;
    logic          c_en = 1'b0;
    logic          c_spk = 1'b0;
    logic [CW-1:0] c_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iz_mode_scheduler #(
        .RST_CYCLES (RSTC),
        .RUN_CYCLES (RUNC),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mode_mask  (mode_mask),
        .i_level    (i_level),
        .nrn_spike  (nrn_spike),
        .nrn_rst    (nrn_rst),
        .nrn_select (nrn_select),
        .nrn_I      (nrn_I),
        .busy       (busy),
        .done       (done),
        .rpt_valid  (rpt_valid),
        .rpt_mode   (rpt_mode),
        .rpt_count  (rpt_count),
        .rpt_ready  (rpt_ready)
    );

    iz_spike_counter #(
        .CNT_W (CW)
    ) u_sat (
        .clk   (clk),
        .rst   (rst),
        .clr   (c_clr),
        .en    (c_en),
        .spike (c_spk),
        .count (c_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered while the DUT sits in SCAN; leaves it in the next SCAN.
    task automatic do_mode(
        input logic [2:0]  m,
        input logic [19:0] pat,
        input logic [3:0]  expc,
        input int          wait_cyc
    );
        int n;
        logic ok;
        logic [CW-1:0] held;
        tick();
        check("sel_hold", nrn_select, m);
        n = 0;
        while (nrn_rst && n < 50) begin
            n++;
            tick();
        end
        check("hold_len", n, RSTC);
        ok = 1'b1;
        for (int i = 0; i < RUNC; i++) begin
            nrn_spike = pat[i];
            if (nrn_rst !== 1'b0 || nrn_select !== m) ok = 1'b0;
            tick();
        end
        nrn_spike = 1'b0;
        check("run_len", ok, 1);
        check("rpt_rst", nrn_rst, 1);
        check("rpt_valid", rpt_valid, 1);
        check("rpt_mode", rpt_mode, m);
        check("rpt_count", rpt_count, expc);
        held = rpt_count;
        ok = 1'b1;
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            if (!rpt_valid || rpt_count !== held || rpt_mode !== m)
                ok = 1'b0;
        end
        check("rpt_stable", ok, 1);
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        check("rpt_drop", rpt_valid, 0);
    endtask

    task automatic finish_seq();
        tick();
        check("done_pulse", done, 1);
        tick();
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int n;
        logic ok;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_nrn_rst", nrn_rst, 1);
        check("rst_sel", nrn_select, 0);
        check("rst_I", nrn_I, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", rpt_valid, 0);
        check("rst_mode", rpt_mode, 0);
        check("rst_count", rpt_count, 0);

        // Single mode, three one-cycle pulses.
        mode_mask = 8'h01;
        i_level   = 5'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_I", nrn_I, 2);
        do_mode(3'd0, 20'h00444, 4'd3, 0);
        finish_seq();

        // Three modes in ascending order; first waits on ready.
        mode_mask = 8'hA4;
        i_level   = 5'd9;
        start     = 1'b1;
        tick();
        start = 1'b0;
        do_mode(3'd2, 20'h00A9F, 4'd4, 10);
        do_mode(3'd5, 20'h80001, 4'd2, 0);
        do_mode(3'd7, 20'hAAAAA, 4'd10, 2);
        check("t2_I", nrn_I, 9);
        finish_seq();

        // Empty mask, with abort in IDLE losing to start.
        mode_mask = 8'h00;
        start     = 1'b1;
        abort     = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t3_busy", busy, 1);
        check("t3_scan_done", done, 0);
        tick();
        check("t3_done", done, 1);
        check("t3_valid", rpt_valid, 0);
        tick();
        check("t3_done_end", done, 0);
        check("t3_idle", busy, 0);

        // Abort in RUN; a start while busy is ignored.
        mode_mask = 8'h0C;
        i_level   = 5'd5;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n = 0;
        while (nrn_rst && n < 50) begin
            if (n == 1) begin
                start     = 1'b1;
                mode_mask = 8'hFF;
                i_level   = 5'd31;
            end else begin
                start = 1'b0;
            end
            n++;
            tick();
        end
        start = 1'b0;
        check("t4_hold_len", n, RSTC);
        check("t4_I", nrn_I, 5);
        check("t4_sel", nrn_select, 2);
        nrn_spike = 1'b1;
        tick();
        nrn_spike = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_nrn_rst", nrn_rst, 1);
        check("t4_valid", rpt_valid, 0);
        check("t4_sel_clr", nrn_select, 0);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (done || rpt_valid || busy) ok = 1'b0;
            tick();
        end
        check("t4_quiet", ok, 1);

        // Synchronous reset mid-operation.
        mode_mask = 8'h01;
        i_level   = 5'd7;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t5_I_pre", nrn_I, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_I", nrn_I, 0);
        check("t5_nrn_rst", nrn_rst, 1);

        // Counter saturation at 2^CW-1.
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        c_en  = 1'b1;
        c_spk = 1'b1;
        repeat (5) tick();
        c_spk = 1'b0;
        tick();
        check("sat_level", c_cnt, 1);
        for (int i = 0; i < 14; i++) begin
            c_spk = 1'b1;
            tick();
            c_spk = 1'b0;
            tick();
        end
        check("sat_15", c_cnt, 15);
        for (int i = 0; i < 5; i++) begin
            c_spk = 1'b1;
            tick();
            c_spk = 1'b0;
            tick();
        end
        check("sat_hold", c_cnt, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
